// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode constants, NOP word and loader FSM states shared by the loader and packer.
package riscv_pkg;
  localparam logic [6:0] OP_R = 7'h33;
  localparam logic [6:0] OP_I = 7'h13;
  localparam logic [6:0] OP_S = 7'h23;
  localparam logic [6:0] OP_B = 7'h63;
  localparam logic [6:0] OP_U = 7'h37;
  localparam logic [6:0] OP_J = 7'h6F;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
endpackage

// File: rtl/riscv_instr_pack.sv
// riscv_instr_pack: combinational field->RV32I word packer; range check output under IMM_RANGE_CHECK_EN.
module riscv_instr_pack
  import riscv_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        unsup
`ifdef IMM_RANGE_CHECK_EN
  , output logic      range_err
`endif
);
  always_comb begin
    word  = RV_NOP;
    unsup = 1'b0;
    case (op)
      OP_R:    word = {funct7, rs2, rs1, funct3, rd, op};
      OP_I:    word = {imm[11:0], rs1, funct3, rd, op};
      OP_S:    word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
      OP_B:    word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
      OP_U:    word = {imm[19:0], rd, op};
      OP_J:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: unsup = 1'b1;
    endcase
  end
`ifdef IMM_RANGE_CHECK_EN
  always_comb begin
    range_err = 1'b0;
    case (op)
      OP_I, OP_S: range_err = imm[31:11] != {21{imm[11]}};
      OP_B:       range_err = (imm[31:12] != {20{imm[12]}}) | imm[0];
      OP_J:       range_err = (imm[31:20] != {12{imm[20]}}) | imm[0];
      OP_U:       range_err = imm[31:20] != {12{imm[19]}};
      default:    range_err = 1'b0;
    endcase
  end
`else
  logic unused_imm;
  assign unused_imm = ^imm[31:21];
`endif
endmodule

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs decoded fields into RV32I words and writes them to sequential memory words.
// Optional IMM_RANGE_CHECK_EN adds sticky range_err_o for unrepresentable immediates.
module instr_encode_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  last_i,
  input  logic [6:0]            op_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [31:0]           imm_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_data_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  done_o,
  output logic                  full_o,
  output logic                  unsup_o
`ifdef IMM_RANGE_CHECK_EN
  , output logic                range_err_o
`endif
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  state_t state;
  logic last_q, unsup;
  logic [31:0] word;
  logic [ADDR_WIDTH:0] count_nx;
`ifdef IMM_RANGE_CHECK_EN
  logic range_err;
`endif
  assign count_nx = count_o + 1'b1;
  riscv_instr_pack u_pack (
    .op(op_i), .rd(rd_i), .rs1(rs1_i), .rs2(rs2_i), .funct3(funct3_i), .funct7(funct7_i),
    .imm(imm_i), .word(word), .unsup(unsup)
`ifdef IMM_RANGE_CHECK_EN
    , .range_err(range_err)
`endif
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ready_o    <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      count_o    <= '0;
      done_o     <= 1'b0;
      full_o     <= 1'b0;
      unsup_o    <= 1'b0;
      last_q     <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
      range_err_o <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (start_i) begin
          state      <= ACCEPT;
          ready_o    <= 1'b1;
          mem_addr_o <= '0;
          count_o    <= '0;
          done_o     <= 1'b0;
          full_o     <= 1'b0;
          unsup_o    <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
          range_err_o <= 1'b0;
`endif
        end
        ACCEPT: if (valid_i) begin
          state      <= WRITE;
          ready_o    <= 1'b0;
          mem_we_o   <= 1'b1;
          mem_data_o <= word;
          last_q     <= last_i;
          unsup_o    <= unsup_o | unsup;
`ifdef IMM_RANGE_CHECK_EN
          range_err_o <= range_err_o | range_err;
`endif
        end
        WRITE: if (mem_ready_i) begin
          mem_we_o   <= 1'b0;
          mem_addr_o <= mem_addr_o + 1'b1;
          count_o    <= count_nx;
          if (last_q || count_nx == DEPTH_C) begin
            state  <= DONE;
            done_o <= 1'b1;
            full_o <= (count_nx == DEPTH_C) && !last_q;
          end else begin
            state   <= ACCEPT;
            ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader: directed vector table plus hand sequences for stall, full, unsupported and reset cases.
module tb_instr_encode_loader;
  localparam int AW = 8;
  localparam int DEPTH = 256;
  logic clk = 0, reset = 0, start_i = 0, valid_i = 0, last_i = 0, mem_ready_i = 1;
  logic [6:0] op_i = 0, funct7_i = 0;
  logic [4:0] rd_i = 0, rs1_i = 0, rs2_i = 0;
  logic [2:0] funct3_i = 0;
  logic [31:0] imm_i = 0;
  logic ready_o, mem_we_o, done_o, full_o, unsup_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [AW:0] count_o;
`ifdef IMM_RANGE_CHECK_EN
  logic range_err_o;
`endif
  int checks = 0, errors = 0;

  typedef struct {
    string name;
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .valid_i(valid_i), .ready_o(ready_o),
    .last_i(last_i), .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
    .count_o(count_o), .done_o(done_o), .full_o(full_o), .unsup_o(unsup_o)
`ifdef IMM_RANGE_CHECK_EN
    , .range_err_o(range_err_o)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start();
    start_i = 1;
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic beat(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic last);
    int n = 0;
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(ready_o), 1);
    op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; funct3_i = f3; funct7_i = f7; imm_i = imm;
    valid_i = 1; last_i = last;
    @(negedge clk);
    valid_i = 0; last_i = 0;
  endtask

  initial begin
    vecs[0] = '{"add",  7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0,        32'h002081B3};
    vecs[1] = '{"sub",  7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'h0,        32'h407302B3};
    vecs[2] = '{"addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h7FF,      32'h7FF00093};
    vecs[3] = '{"sw",   7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h8,        32'h0020A423};
    vecs[4] = '{"swneg",7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'hFFFFFFFC, 32'hFE512E23};
    vecs[5] = '{"bneg", 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE208EE3};
    vecs[6] = '{"beq",  7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h8,        32'h00000463};
    vecs[7] = '{"lui",  7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345,    32'h123452B7};
    vecs[8] = '{"jal",  7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h800,      32'h001000EF};
    vecs[9] = '{"jneg", 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFE, 32'hFFFFF06F};

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready_o), 0);
    check("rst_we", 32'(mem_we_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_full", 32'(full_o), 0);
    check("rst_unsup", 32'(unsup_o), 0);
    check("rst_count", 32'(count_o), 0);
    check("rst_addr", 32'(mem_addr_o), 0);
    check("rst_data", mem_data_o, 0);
    reset = 1;
    @(negedge clk);
    check("idle_ready", 32'(ready_o), 0);

    start();
    beat(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1);
    check("s1_we", 32'(mem_we_o), 1);
    check("s1_addr", 32'(mem_addr_o), 0);
    check("s1_data", mem_data_o, 32'hFFF00093);
    @(negedge clk);
    check("s1_we_off", 32'(mem_we_o), 0);
    check("s1_done", 32'(done_o), 1);
    check("s1_count", 32'(count_o), 1);
    check("s1_full", 32'(full_o), 0);

    start();
    check("s2_done_clr", 32'(done_o), 0);
    check("s2_count_clr", 32'(count_o), 0);
    for (int i = 0; i < 10; i++) begin
      beat(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7, vecs[i].imm, i == 9);
      check({vecs[i].name, "_data"}, mem_data_o, vecs[i].word);
      check({vecs[i].name, "_addr"}, 32'(mem_addr_o), 32'(i));
      @(negedge clk);
    end
    check("s2_done", 32'(done_o), 1);
    check("s2_count", 32'(count_o), 10);
    check("s2_unsup", 32'(unsup_o), 0);

    start();
    mem_ready_i = 0;
    beat(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1);
    for (int k = 0; k < 5; k++) begin
      start_i = (k == 2);
      check("stall_we", 32'(mem_we_o), 1);
      check("stall_addr", 32'(mem_addr_o), 0);
      check("stall_data", mem_data_o, 32'h001000EF);
      check("stall_ready", 32'(ready_o), 0);
      check("stall_count", 32'(count_o), 0);
      @(negedge clk);
    end
    start_i = 0;
    mem_ready_i = 1;
    @(negedge clk);
    check("stall_count_done", 32'(count_o), 1);
    check("stall_we_off", 32'(mem_we_o), 0);
    check("stall_done", 32'(done_o), 1);

    start();
    for (int i = 0; i < DEPTH; i++) begin
      beat(7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 0);
      check("fill_addr", 32'(mem_addr_o), 32'(i));
      check("fill_data", mem_data_o, (32'(i) << 20) | (32'(i & 31) << 7) | 32'h13);
      @(negedge clk);
    end
    check("full_done", 32'(done_o), 1);
    check("full_full", 32'(full_o), 1);
    check("full_count", 32'(count_o), DEPTH);
    check("full_addr_wrap", 32'(mem_addr_o), 0);
    valid_i = 1;
    repeat (4) begin
      @(negedge clk);
      check("full_stall_ready", 32'(ready_o), 0);
      check("full_stall_we", 32'(mem_we_o), 0);
      check("full_stall_count", 32'(count_o), DEPTH);
    end
    valid_i = 0;

    start();
    check("s5_full_clr", 32'(full_o), 0);
    check("s5_addr_clr", 32'(mem_addr_o), 0);
    beat(7'h7F, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1);
    check("unsup_data", mem_data_o, 32'h00000013);
    @(negedge clk);
    check("unsup_flag", 32'(unsup_o), 1);
    check("unsup_done", 32'(done_o), 1);
    start();
    check("unsup_clr", 32'(unsup_o), 0);
    check("unsup_addr0", 32'(mem_addr_o), 0);
    check("unsup_count0", 32'(count_o), 0);
    beat(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1);
    check("trunc_data", mem_data_o, 32'h80000013);
    check("trunc_addr", 32'(mem_addr_o), 0);
    @(negedge clk);
`ifdef IMM_RANGE_CHECK_EN
    check("range_err_set", 32'(range_err_o), 1);
`endif
    start();
`ifdef IMM_RANGE_CHECK_EN
    check("range_err_clr", 32'(range_err_o), 0);
`endif

    mem_ready_i = 0;
    beat(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5, 1);
    check("mid_we", 32'(mem_we_o), 1);
    #2 reset = 0;
    #1;
    check("mid_rst_we", 32'(mem_we_o), 0);
    check("mid_rst_data", mem_data_o, 0);
    @(negedge clk);
    reset = 1;
    mem_ready_i = 1;
    @(negedge clk);
    check("mid_rst_count", 32'(count_o), 0);
    check("mid_rst_done", 32'(done_o), 0);
    check("mid_rst_ready", 32'(ready_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
